letter_scan_ctrl: RTL and testbench

LETTER_SCAN_CTRL -- requirements
Module: letter_scan_ctrl

---
 rtl/letter_scan_ctrl_if.sv | 31 +++
 rtl/letter_scan_ctrl.sv | 86 ++++++++
 tb/tb_letter_scan_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/letter_scan_ctrl_if.sv
// Letter-stream / word-report bus for letter_scan_ctrl.
// master = letter producer and report consumer; slave = the scan controller.
interface letter_scan_ctrl_if #(
  parameter int CW = 4,
  parameter int TW = 8
);
  logic          in_valid;
  logic [5:0]    in_code;
  logic          in_last;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] word_len;
  logic [CW-1:0] word_vowels;
  logic          word_novowel;
  logic          word_sat;
  logic [TW-1:0] total_vowels;
  logic          busy;

  modport master (
    output in_valid, in_code, in_last, out_ready,
    input  in_ready, out_valid, word_len, word_vowels, word_novowel,
           word_sat, total_vowels, busy
  );

  modport slave (
    input  in_valid, in_code, in_last, out_ready,
    output in_ready, out_valid, word_len, word_vowels, word_novowel,
           word_sat, total_vowels, busy
  );
endinterface

// File: rtl/letter_scan_ctrl.sv
// Counts letters and vowels per word from a 6-bit one-of-A..F letter stream and
// holds a per-word report until the consumer takes it; keeps a running vowel total.
module letter_scan_ctrl #(
  parameter int CW = 4,
  parameter int TW = 8
) (
  input  logic               clk,
  input  logic               reset,
  letter_scan_ctrl_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

  localparam logic [CW-1:0] MAXV = '1;

  state_t        state;
  logic [CW-1:0] len_q, vow_q;
  logic [TW-1:0] tot_q;
  logic          sat_q, nov_q, ovld_q, irdy_q, busy_q;

  logic [5:0]    c;
  logic          vowel, acc;
  logic [CW-1:0] len_nxt, vow_nxt;

  assign c = bus.in_code;
  // bit5..bit0 = A..F
  assign vowel = (~c[5] & ~c[3] & ~c[2] &  c[1] & ~c[0])
               | ( c[4] &  c[3] & ~c[2] &  c[1] & ~c[0])
               | ( c[5] & ~c[4] & ~c[2] & ~c[1] &  c[0]);

  assign acc     = bus.in_valid & irdy_q;
  assign len_nxt = (len_q == MAXV) ? len_q : len_q + 1'b1;
  assign vow_nxt = (vowel && vow_q != MAXV) ? vow_q + 1'b1 : vow_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      len_q  <= '0;
      vow_q  <= '0;
      tot_q  <= '0;
      sat_q  <= 1'b0;
      nov_q  <= 1'b0;
      ovld_q <= 1'b0;
      irdy_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      case (state)
        IDLE, SCAN: if (acc) begin
          len_q <= len_nxt;
          vow_q <= vow_nxt;
          tot_q <= tot_q + TW'(vowel);
          if (len_q == MAXV) sat_q <= 1'b1;
          busy_q <= 1'b1;
          if (bus.in_last) begin
            // report fields are final from here until the handshake
            state  <= REPORT;
            ovld_q <= 1'b1;
            irdy_q <= 1'b0;
            nov_q  <= (vow_nxt == '0);
          end else begin
            state <= SCAN;
          end
        end
        REPORT: if (bus.out_ready) begin
          state  <= IDLE;
          len_q  <= '0;
          vow_q  <= '0;
          sat_q  <= 1'b0;
          nov_q  <= 1'b0;
          ovld_q <= 1'b0;
          irdy_q <= 1'b1;
          busy_q <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready     = irdy_q;
  assign bus.out_valid    = ovld_q;
  assign bus.word_len     = len_q;
  assign bus.word_vowels  = vow_q;
  assign bus.word_novowel = nov_q;
  assign bus.word_sat     = sat_q;
  assign bus.total_vowels = tot_q;
  assign bus.busy         = busy_q;
endmodule

// File: tb/tb_letter_scan_ctrl.sv
// Directed bench for letter_scan_ctrl: a word model pushes expected reports to a
// queue as letters are driven; reports are popped and compared when out_valid rises.
module tb_letter_scan_ctrl;
  localparam int CW = 4;
  localparam int TW = 8;
  localparam int MAXW = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;

  letter_scan_ctrl_if #(.CW(CW), .TW(TW)) bus();
  letter_scan_ctrl #(.CW(CW), .TW(TW)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct { int len; int vow; int nov; int sat; int total; } rpt_t;
  rpt_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;
  int m_len, m_vow, m_sat;
  logic [TW-1:0] m_total;

  function automatic bit is_vowel(input logic [5:0] code);
    case (code)
      6'h02, 6'h12, 6'h1A, 6'h3A, 6'h21, 6'h29: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  task automatic do_reset(input bit offer_letter);
    @(negedge clk);
    reset = 1'b1;
    bus.in_valid = offer_letter;
    bus.in_code  = 6'h02;
    bus.in_last  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    m_len = 0; m_vow = 0; m_sat = 0; m_total = '0;
  endtask

  // one letter, accepted on the next rising edge; returns at edge+1
  task automatic send(input logic [5:0] code, input bit last);
    @(negedge clk);
    chk("in_ready_before_letter", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    if (m_len == MAXW) m_sat = 1;
    if (m_len < MAXW) m_len++;
    if (is_vowel(code)) begin
      if (m_vow < MAXW) m_vow++;
      m_total = m_total + 1'b1;
    end
    if (last) begin
      exp_q.push_back('{len: m_len, vow: m_vow, nov: (m_vow == 0) ? 1 : 0,
                        sat: m_sat, total: int'(m_total)});
      m_len = 0; m_vow = 0; m_sat = 0;
    end
  endtask

  task automatic check_report(input string tag, input rpt_t e);
    chk({tag, "_out_valid"}, int'(bus.out_valid), 1);
    chk({tag, "_in_ready"},  int'(bus.in_ready), 0);
    chk({tag, "_busy"},      int'(bus.busy), 1);
    chk({tag, "_len"},       int'(bus.word_len), e.len);
    chk({tag, "_vowels"},    int'(bus.word_vowels), e.vow);
    chk({tag, "_novowel"},   int'(bus.word_novowel), e.nov);
    chk({tag, "_sat"},       int'(bus.word_sat), e.sat);
    chk({tag, "_total"},     int'(bus.total_vowels), e.total);
  endtask

  // wait for the report, optionally stall it, then take it; returns at edge+1
  task automatic collect(input string tag, input int hold);
    rpt_t e;
    int waited = 0;
    @(negedge clk);
    while (!bus.out_valid && waited < 8) begin
      waited++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, waited, 0);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_queue observed=empty expected=report", tag);
      return;
    end
    e = exp_q.pop_front();
    check_report(tag, e);
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.in_code  = 6'h02;
      bus.in_last  = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
      @(negedge clk);
      check_report({tag, "_hold"}, e);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, "_post_out_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_post_busy"},      int'(bus.busy), 0);
    chk({tag, "_post_len"},       int'(bus.word_len), 0);
    chk({tag, "_post_sat"},       int'(bus.word_sat), 0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    // reset state
    do_reset(1'b1);
    @(negedge clk);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_in_ready",  int'(bus.in_ready), 1);
    chk("rst_busy",      int'(bus.busy), 0);
    chk("rst_total",     int'(bus.total_vowels), 0);
    chk("rst_len",       int'(bus.word_len), 0);

    // mixed word, immediate take; out_ready while idle is harmless
    bus.out_ready = 1'b1;
    send(6'h03, 1'b0);
    bus.out_ready = 1'b0;
    chk("scan_busy", int'(bus.busy), 1);
    send(6'h12, 1'b0);
    send(6'h00, 1'b0);
    send(6'h21, 1'b1);
    collect("word4", 0);

    // single consonant, stalled report ignores offered letters
    send(6'h03, 1'b1);
    collect("stall", 5);

    // saturation
    do_reset(1'b0);
    for (int i = 0; i < 17; i++) send(6'h02, i == 16);
    collect("sat17", 0);

    // total wrap: 257 vowels in 16-letter words plus one
    do_reset(1'b0);
    for (int i = 0; i < 257; i++) begin
      send((i % 2 == 0) ? 6'h29 : 6'h3A, (i % 16 == 15) || (i == 256));
      if ((i % 16 == 15) || (i == 256)) collect("wrap", 0);
    end
    chk("wrap_total_final", int'(bus.total_vowels), 1);

    // reset mid-word discards the partial word and the total
    do_reset(1'b0);
    send(6'h02, 1'b0);
    send(6'h03, 1'b0);
    send(6'h12, 1'b0);
    do_reset(1'b1);
    @(negedge clk);
    chk("midrst_len",   int'(bus.word_len), 0);
    chk("midrst_total", int'(bus.total_vowels), 0);
    send(6'h29, 1'b1);
    collect("midrst", 0);

    // back-to-back words: letter accepted the cycle after the handshake
    send(6'h21, 1'b1);
    collect("b2b_a", 0);
    send(6'h3A, 1'b0);
    send(6'h1A, 1'b1);
    collect("b2b_b", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
